// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes and execute-FSM state encoding
package alu_pkg;

    // One code list shared by the ALU decoder and the execute-stage ALU.
    typedef enum logic [3:0] {
        ALU_ADD     = 4'b0000,
        ALU_SUB     = 4'b0001,
        ALU_MULT    = 4'b0010,
        ALU_DIV     = 4'b0011,
        ALU_SL      = 4'b0100,
        ALU_SR      = 4'b0101,
        ALU_AND     = 4'b0110,
        ALU_OR      = 4'b0111,
        ALU_XOR     = 4'b1000,
        ALU_NOR     = 4'b1001,
        ALU_JR      = 4'b1010,
        ALU_NAND    = 4'b1011,
        ALU_NOT     = 4'b1100,
        ALU_SLT     = 4'b1101,
        ALU_SGT     = 4'b1110,
        ALU_ILLEGAL = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative shift-add multiplier / restoring divider
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   load            capture operands and start a WIDTH-step run
//   is_div          1: unsigned divide a / b, 0: unsigned multiply a * b
//   a, b            operands, sampled only on load
//   lo, hi          values the registers take after the current step
//                   (mult: low/high product, div: quotient/remainder)
//   last            the current step is the final one
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    // r_hi: accumulator / partial remainder
    // r_lo: multiplier shifting out, product low shifting in / dividend -> quotient
    // r_op: multiplicand / divisor
    logic [WIDTH-1:0] r_hi, r_lo, r_op;
    logic [CW-1:0]    count;
    logic             div_mode;

    logic [WIDTH-1:0] mul_add;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    always_comb begin
        mul_add   = r_lo[0] ? r_op : '0;
        mul_sum   = {1'b0, r_hi} + {1'b0, mul_add};
        div_shift = {r_hi, r_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, r_op};
        if (div_mode) begin
            // Partial remainder is always below the divisor, so the top bit
            // of the difference is a clean borrow flag.
            if (!div_diff[WIDTH]) begin
                hi = div_diff[WIDTH-1:0];
                lo = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi = div_shift[WIDTH-1:0];
                lo = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi = mul_sum[WIDTH:1];
            lo = {mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_op     <= '0;
            count    <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            r_hi     <= '0;
            r_lo     <= is_div ? a : b;
            r_op     <= is_div ? b : a;
            div_mode <= is_div;
            count    <= CW'(WIDTH);
        end else if (count != '0) begin
            r_hi  <= hi;
            r_lo  <= lo;
            count <= count - CW'(1);
        end
    end

    assign last = (count == CW'(1));

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - execute-stage ALU with start/busy/done handshake
//
// Optional feature macro: ALU_HILO_EN (adds hi output: upper product / remainder)
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               request, sampled only in IDLE
//   alucontrol          operation code (alu_op_t)
//   a, b                operands, captured on acceptance
//   result, zero        registered result and (result == 0)
//   hi                  (ALU_HILO_EN only) upper product / remainder, else 0
//   busy                high while mult/div iterate
//   done                one-cycle pulse when result is valid
//   divzero, illegal    status flags, set with done, cleared on next accept
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
`ifdef ALU_HILO_EN
    output logic [WIDTH-1:0] hi,
`endif
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t       state, state_next;
    alu_op_t          op;
    logic             accept;
    logic             iter_load;
    logic             iter_last;
    logic [WIDTH-1:0] iter_lo, iter_hi;
    logic [WIDTH-1:0] sc_result, sc_hi;
    logic [SHW-1:0]   shamt;

    assign op     = alu_op_t'(alucontrol);
    assign shamt  = b[SHW-1:0];
    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        iter_load  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == ALU_MULT || (op == ALU_DIV && b != '0)) begin
                        iter_load  = 1'b1;
                        state_next = ITER;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            ITER: begin
                busy = 1'b1;
                if (iter_last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle operations; ALU_DIV only lands here when b == 0.
    always_comb begin
        sc_result = '0;
        sc_hi     = '0;
        case (op)
            ALU_ADD:  sc_result = a + b;
            ALU_SUB:  sc_result = a - b;
            ALU_DIV:  begin
                sc_result = '1;
                sc_hi     = a;
            end
            ALU_SL:   sc_result = a << shamt;
            ALU_SR:   sc_result = a >> shamt;
            ALU_AND:  sc_result = a & b;
            ALU_OR:   sc_result = a | b;
            ALU_XOR:  sc_result = a ^ b;
            ALU_NOR:  sc_result = ~(a | b);
            ALU_JR:   sc_result = a;
            ALU_NAND: sc_result = ~(a & b);
            ALU_NOT:  sc_result = ~a;
            ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SGT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
            default:  sc_result = '0;
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .load   (iter_load),
        .is_div (op == ALU_DIV),
        .a      (a),
        .b      (b),
        .lo     (iter_lo),
        .hi     (iter_hi),
        .last   (iter_last)
    );

`ifndef ALU_HILO_EN
    logic unused_hi;
    assign unused_hi = ^{iter_hi, sc_hi};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result  <= '0;
            zero    <= 1'b1;
            divzero <= 1'b0;
            illegal <= 1'b0;
`ifdef ALU_HILO_EN
            hi      <= '0;
`endif
        end else if (accept && !iter_load) begin
            result  <= sc_result;
            zero    <= (sc_result == '0);
            divzero <= (op == ALU_DIV);
            illegal <= (op == ALU_ILLEGAL);
`ifdef ALU_HILO_EN
            hi      <= sc_hi;
`endif
        end else if (accept) begin
            divzero <= 1'b0;
            illegal <= 1'b0;
        end else if (state == ITER && iter_last) begin
            result  <= iter_lo;
            zero    <= (iter_lo == '0);
`ifdef ALU_HILO_EN
            hi      <= iter_hi;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - self-checking bench for multicycle_alu
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alucontrol = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] result;
    logic        zero, busy, done, divzero, illegal;
`ifdef ALU_HILO_EN
    logic [31:0] hi;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .result     (result),
        .zero       (zero),
`ifdef ALU_HILO_EN
        .hi         (hi),
`endif
        .busy       (busy),
        .done       (done),
        .divzero    (divzero),
        .illegal    (illegal)
    );

    // Reference model straight from the operation table.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = {32'd0, x} * {32'd0, y};
        case (op)
            4'd0:  return x + y;
            4'd1:  return x - y;
            4'd2:  return p[31:0];
            4'd3:  return (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'd4:  return x << y[4:0];
            4'd5:  return x >> y[4:0];
            4'd6:  return x & y;
            4'd7:  return x | y;
            4'd8:  return x ^ y;
            4'd9:  return ~(x | y);
            4'd10: return x;
            4'd11: return ~(x & y);
            4'd12: return ~x;
            4'd13: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd14: return ($signed(x) > $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_hi(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = {32'd0, x} * {32'd0, y};
        if (op == 4'd2) return p[63:32];
        if (op == 4'd3) return (y == 0) ? x : x % y;
        return 32'd0;
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] y);
        return (op == 4'd2 || (op == 4'd3 && y != 0)) ? 33 : 1;
    endfunction

    // Drives one request and follows it to done. A second start (AND, random
    // operands) is asserted during cycle poke_at; 0 disables it.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input int poke_at, output int lat, output int busy_cnt,
                         output logic done_after);
        @(negedge clk);
        alucontrol = op; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; alucontrol = 4'($urandom_range(0, 15));
        lat = 1; busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (lat == poke_at) alucontrol = 4'd6;
            start = (lat == poke_at);
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        if (lat == poke_at) alucontrol = 4'd6;
        start = (lat == poke_at);
        @(negedge clk);
        start = 1'b0;
        done_after = done;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({result, zero, busy, done, divzero, illegal} !== {32'd0, 5'b10000}) begin
            n_fail++;
            $display("FAIL reset_hold: got r=%h z%b b%b d%b dz%b il%b", result, zero, busy, done, divzero, illegal);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({result, zero, busy, done, divzero, illegal} !== {32'd0, 5'b10000}) begin
            n_fail++;
            $display("FAIL reset_release: got r=%h z%b b%b d%b dz%b il%b", result, zero, busy, done, divzero, illegal);
        end
`ifdef ALU_HILO_EN
        n_tests++;
        if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
`endif
    endtask

    task automatic test_single_cycle;
        int lat, bc;
        logic da;
        logic [3:0]  ops [4] = '{4'd0, 4'd1, 4'd13, 4'd14};
        logic [31:0] xs  [4] = '{32'd5, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ys  [4] = '{32'd7, 32'd3, 32'd1, 32'd1};
        logic [31:0] want[4] = '{32'd12, 32'd0, 32'd1, 32'd0};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], xs[i], ys[i], 0, lat, bc, da);
            n_tests++;
            if ({result, zero} !== {want[i], want[i] == 32'd0}) begin
                n_fail++;
                $display("FAIL single_op%0d: got r=%h z=%b want r=%h", ops[i], result, zero, want[i]);
            end
            n_tests++;
            if (lat != 1 || bc != 0 || da !== 1'b0) begin
                n_fail++;
                $display("FAIL single_timing%0d: got lat=%0d busy=%0d done_after=%b want 1/0/0", ops[i], lat, bc, da);
            end
        end
    endtask

    task automatic test_muldiv;
        int lat, bc;
        logic da;
        logic [3:0]  ops [2] = '{4'd2, 4'd3};
        logic [31:0] xs  [2] = '{32'h0000_FFFF, 32'd100};
        logic [31:0] ys  [2] = '{32'h0001_0001, 32'd7};
        logic [31:0] want[2] = '{32'hFFFF_FFFF, 32'd14};
        logic [31:0] wanth[2] = '{32'd0, 32'd2};
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], xs[i], ys[i], 0, lat, bc, da);
            n_tests++;
            if ({result, zero, divzero} !== {want[i], 2'b00}) begin
                n_fail++;
                $display("FAIL muldiv_op%0d: got r=%h z=%b dz=%b want r=%h", ops[i], result, zero, divzero, want[i]);
            end
            n_tests++;
            if (lat != 33 || bc != 32 || da !== 1'b0) begin
                n_fail++;
                $display("FAIL muldiv_timing%0d: got lat=%0d busy=%0d done_after=%b want 33/32/0", ops[i], lat, bc, da);
            end
`ifdef ALU_HILO_EN
            n_tests++;
            if (hi !== wanth[i]) begin n_fail++; $display("FAIL muldiv_hi%0d: got %h want %h", ops[i], hi, wanth[i]); end
`else
            if (wanth[i] != wanth[i]) n_tests++;
`endif
        end
    endtask

    task automatic test_divzero;
        int lat, bc;
        logic da;
        issue(4'd3, 32'd9, 32'd0, 0, lat, bc, da);
        n_tests++;
        if ({result, zero, divzero, illegal} !== {32'hFFFF_FFFF, 3'b010} || lat != 1 || bc != 0) begin
            n_fail++;
            $display("FAIL divzero: got r=%h z=%b dz=%b il=%b lat=%0d busy=%0d want ffffffff/0/1/0 lat 1", result, zero, divzero, illegal, lat, bc);
        end
`ifdef ALU_HILO_EN
        n_tests++;
        if (hi !== 32'd9) begin n_fail++; $display("FAIL divzero_hi: got %h want 9", hi); end
`endif
    endtask

    task automatic test_start_while_busy;
        int lat, bc;
        logic da;
        issue(4'd2, 32'h0000_FFFF, 32'h0001_0001, 10, lat, bc, da);
        n_tests++;
        if (result !== 32'hFFFF_FFFF || lat != 33 || bc != 32) begin
            n_fail++;
            $display("FAIL start_busy: got r=%h lat=%0d busy=%0d want ffffffff 33/32", result, lat, bc);
        end
        // start during the done cycle must be dropped
        issue(4'd0, 32'd40, 32'd2, 1, lat, bc, da);
        n_tests++;
        if (result !== 32'd42 || da !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_done: got r=%h done_after=%b busy=%b want 0000002a 0 0", result, da, busy);
        end
    endtask

    task automatic test_illegal;
        int lat, bc;
        logic da;
        issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 0, lat, bc, da);
        n_tests++;
        if ({result, zero, illegal, divzero} !== {32'd0, 3'b110} || lat != 1) begin
            n_fail++;
            $display("FAIL illegal: got r=%h z=%b il=%b dz=%b lat=%0d want 0/1/1/0 lat 1", result, zero, illegal, divzero, lat);
        end
        issue(4'd0, 32'd1, 32'd1, 0, lat, bc, da);
        n_tests++;
        if ({result, illegal} !== {32'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_clear: got r=%h il=%b want 2/0", result, illegal);
        end
    endtask

    task automatic test_reset_mid_op;
        int lat, bc;
        logic da;
        logic seen;
        @(negedge clk);
        a = 32'd100; b = 32'd7; alucontrol = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({result, zero, busy, done, divzero, illegal} !== {32'd0, 5'b10000}) begin
            n_fail++;
            $display("FAIL reset_async: got r=%h z%b b%b d%b dz%b il%b", result, zero, busy, done, divzero, illegal);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_no_done: got activity=%b want 0", seen); end
        issue(4'd0, 32'd2, 32'd2, 0, lat, bc, da);
        n_tests++;
        if ({result, zero} !== {32'd4, 1'b0} || lat != 1) begin
            n_fail++;
            $display("FAIL reset_then_add: got r=%h z=%b lat=%0d want 4/0 lat 1", result, zero, lat);
        end
    endtask

    task automatic test_random;
        int lat, bc;
        logic da;
        logic [3:0]  op;
        logic [31:0] x, y, wr;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            y  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(8, 28);
            issue(op, x, y, 0, lat, bc, da);
            wr = ref_result(op, x, y);
            n_tests++;
            if ({result, zero, divzero, illegal} !== {wr, wr == 32'd0, op == 4'd3 && y == 0, op == 4'd15}) begin
                n_fail++;
                $display("FAIL rand%0d op%0d a=%h b=%h: got r=%h z%b dz%b il%b want r=%h", i, op, x, y, result, zero, divzero, illegal, wr);
            end
            n_tests++;
            if (lat != ref_latency(op, y) || bc != ref_latency(op, y) - 1 || da !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_timing%0d op%0d: got lat=%0d busy=%0d want %0d", i, op, lat, bc, ref_latency(op, y));
            end
`ifdef ALU_HILO_EN
            n_tests++;
            if (hi !== ref_hi(op, x, y)) begin
                n_fail++;
                $display("FAIL rand_hi%0d op%0d: got %h want %h", i, op, hi, ref_hi(op, x, y));
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_divzero();
        test_start_while_busy();
        test_illegal();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
